// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: Tuse/Tnew encoding, forward-select codes,
// mult/div busy defaults and the register-match helpers used by the hazard unit.
package pipe_pkg;

  localparam int REG_W = 5;
  localparam int T_W   = 2;
  localparam int CNT_W = 4;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [T_W-1:0]   t_val_t;

  // Tuse of 3 means the operand is not read; Tnew never exceeds 2
  localparam t_val_t TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_M  = 2'd1,
    FWD_W  = 2'd2
  } fwd_sel_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic reg_match(input reg_idx_t src, input reg_idx_t a3, input logic we);
    return (src != '0) && (src == a3) && we;
  endfunction

  // M-stage result is only forwardable once it has been produced (Tnew_M == 0)
  function automatic fwd_sel_t fwd_select(input reg_idx_t src,
                                          input reg_idx_t a3_m, input logic we_m,
                                          input t_val_t tnew_m,
                                          input reg_idx_t a3_w, input logic we_w);
    if (reg_match(src, a3_m, we_m) && (tnew_m == '0))
      return FWD_M;
    else if (reg_match(src, a3_w, we_w))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div busy counter: loads the op latency on issue, counts down to zero,
// and reports busy while nonzero. A start while busy reloads the counter.
module md_busy_cnt
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = MULT_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] DIV_LOAD  = DIV_CYCLES[CNT_W-1:0];

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (start)
      cnt <= is_div ? DIV_LOAD : MULT_LOAD;
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forwarding controller for the five-stage pipeline: Tuse/Tnew data
// stalls, mult/div structural stalls, and D/E-stage forward selects.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [T_W-1:0]   tuse_rs_d,
  input  logic [T_W-1:0]   tuse_rt_d,
  input  logic             md_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] a3_e,
  input  logic [REG_W-1:0] a3_m,
  input  logic [REG_W-1:0] a3_w,
  input  logic             we_e,
  input  logic             we_m,
  input  logic             we_w,
  input  logic [T_W-1:0]   tnew_e,
  input  logic [T_W-1:0]   tnew_m,
  input  logic             md_start_e,
  input  logic             md_div_e,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_rst,
  output logic             em_en,
  output logic             mw_en,
  output logic             em_rst,
  output logic             mw_rst,
  output logic [1:0]       fwd_rs_d,
  output logic [1:0]       fwd_rt_d,
  output logic [1:0]       fwd_rs_e,
  output logic [1:0]       fwd_rt_e,
  output logic             md_busy
);

  logic stall_rs;
  logic stall_rt;
  logic md_stall;
  logic stall;

  md_busy_cnt #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (md_start_e),
    .is_div(md_div_e),
    .busy  (md_busy)
  );

  // A stall freezes PC and F/D and injects a bubble into D/E; E/M and M/W always advance
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    md_stall = 1'b0;
    stall    = 1'b0;
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    de_rst   = rst;
    em_en    = 1'b1;
    mw_en    = 1'b1;
    em_rst   = rst;
    mw_rst   = rst;
    fwd_rs_d = FWD_RF;
    fwd_rt_d = FWD_RF;
    fwd_rs_e = FWD_RF;
    fwd_rt_e = FWD_RF;

    stall_rs = (reg_match(rs_d, a3_e, we_e) && (tnew_e > tuse_rs_d)) ||
               (reg_match(rs_d, a3_m, we_m) && (tnew_m > tuse_rs_d));
    stall_rt = (reg_match(rt_d, a3_e, we_e) && (tnew_e > tuse_rt_d)) ||
               (reg_match(rt_d, a3_m, we_m) && (tnew_m > tuse_rt_d));
    md_stall = md_d && (md_start_e || md_busy);
    stall    = stall_rs || stall_rt || md_stall;

    if (stall) begin
      pc_en  = 1'b0;
      fd_en  = 1'b0;
      de_rst = 1'b1;
    end

    // Forwarding is independent of stall; D never forwards from E
    fwd_rs_d = fwd_select(rs_d, a3_m, we_m, tnew_m, a3_w, we_w);
    fwd_rt_d = fwd_select(rt_d, a3_m, we_m, tnew_m, a3_w, we_w);
    fwd_rs_e = fwd_select(rs_e, a3_m, we_m, tnew_m, a3_w, we_w);
    fwd_rt_e = fwd_select(rt_e, a3_m, we_m, tnew_m, a3_w, we_w);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares the DUT outputs.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  logic       clk;
  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, a3_e, a3_m, a3_w;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
  logic       md_d, we_e, we_m, we_w, md_start_e, md_div_e;
  logic       pc_en, fd_en, de_rst, em_en, mw_en, em_rst, mw_rst, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  typedef struct packed {
    logic       pc_en;
    logic       fd_en;
    logic       de_rst;
    logic       em_en;
    logic       mw_en;
    logic       em_rst;
    logic       mw_rst;
    logic [1:0] fwd_rs_d;
    logic [1:0] fwd_rt_d;
    logic [1:0] fwd_rs_e;
    logic [1:0] fwd_rt_e;
    logic       md_busy;
  } exp_t;

  typedef struct {
    string name;
    exp_t  e;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        checks = 0;
  int        errors = 0;

  hazard_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .rs_d      (rs_d),
    .rt_d      (rt_d),
    .tuse_rs_d (tuse_rs_d),
    .tuse_rt_d (tuse_rt_d),
    .md_d      (md_d),
    .rs_e      (rs_e),
    .rt_e      (rt_e),
    .a3_e      (a3_e),
    .a3_m      (a3_m),
    .a3_w      (a3_w),
    .we_e      (we_e),
    .we_m      (we_m),
    .we_w      (we_w),
    .tnew_e    (tnew_e),
    .tnew_m    (tnew_m),
    .md_start_e(md_start_e),
    .md_div_e  (md_div_e),
    .pc_en     (pc_en),
    .fd_en     (fd_en),
    .de_rst    (de_rst),
    .em_en     (em_en),
    .mw_en     (mw_en),
    .em_rst    (em_rst),
    .mw_rst    (mw_rst),
    .fwd_rs_d  (fwd_rs_d),
    .fwd_rt_d  (fwd_rt_d),
    .fwd_rs_e  (fwd_rs_e),
    .fwd_rt_e  (fwd_rt_e),
    .md_busy   (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bundle from a hand-determined stall bit, reset level, selects and busy
  function automatic exp_t mk(input logic st, input logic r,
                              input logic [1:0] frsd, input logic [1:0] frtd,
                              input logic [1:0] frse, input logic [1:0] frte,
                              input logic busy);
    exp_t e;
    e.pc_en    = ~st;
    e.fd_en    = ~st;
    e.de_rst   = st | r;
    e.em_en    = 1'b1;
    e.mw_en    = 1'b1;
    e.em_rst   = r;
    e.mw_rst   = r;
    e.fwd_rs_d = frsd;
    e.fwd_rt_d = frtd;
    e.fwd_rs_e = frse;
    e.fwd_rt_e = frte;
    e.md_busy  = busy;
    return e;
  endfunction

  task automatic idleInputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    a3_e = 0; a3_m = 0; a3_w = 0;
    tuse_rs_d = TUSE_NONE; tuse_rt_d = TUSE_NONE;
    tnew_e = 0; tnew_m = 0;
    md_d = 0; we_e = 0; we_m = 0; we_w = 0;
    md_start_e = 0; md_div_e = 0;
  endtask

  // Inputs are already driven; queue the expectation and advance one cycle
  task automatic applyStimulus(input string name, input exp_t e);
    sb_entry_t ent;
    ent.name = name;
    ent.e    = e;
    sb.push_back(ent);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    sb_entry_t ent;
    exp_t      act;
    ent = sb.pop_front();
    act = {pc_en, fd_en, de_rst, em_en, mw_en, em_rst, mw_rst,
           fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy};
    checks++;
    if (act !== ent.e) begin
      errors++;
      $display("[TB] FAIL %s: got %04h expected %04h", ent.name, act, ent.e);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput();
    end
  end

  initial begin
    idleInputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state
    applyStimulus("reset_idle", mk(0, 1, 0, 0, 0, 0, 0));
    rst = 1'b0;
    applyStimulus("idle", mk(0, 0, 0, 0, 0, 0, 0));

    // lw $1 in E, consumer reads rs=1 with Tuse 0
    rs_d = 1; tuse_rs_d = 0; a3_e = 1; we_e = 1; tnew_e = 2;
    applyStimulus("lw_stall_e", mk(1, 0, 0, 0, 0, 0, 0));
    a3_e = 0; we_e = 0; tnew_e = 0; a3_m = 1; we_m = 1; tnew_m = 1;
    applyStimulus("lw_stall_m", mk(1, 0, 0, 0, 0, 0, 0));
    tnew_m = 0;
    applyStimulus("lw_fwd_m", mk(0, 0, 1, 0, 0, 0, 0));
    a3_m = 0; we_m = 0; a3_w = 1; we_w = 1;
    applyStimulus("lw_fwd_w", mk(0, 0, 2, 0, 0, 0, 0));
    idleInputs();

    // addu $2 in M, rt=2 Tuse 1; M wins over W
    rt_d = 2; tuse_rt_d = 1; a3_m = 2; we_m = 1; tnew_m = 0;
    applyStimulus("addu_fwd_m", mk(0, 0, 0, 1, 0, 0, 0));
    a3_w = 2; we_w = 1;
    applyStimulus("m_beats_w", mk(0, 0, 0, 1, 0, 0, 0));
    tnew_m = 2;
    applyStimulus("m_late_stall_w", mk(1, 0, 0, 2, 0, 0, 0));
    idleInputs();

    // $0 never matches; Tuse 3 never stalls; we=0 never matches
    a3_e = 0; we_e = 1; tnew_e = 2; tuse_rs_d = 0; a3_m = 0; we_m = 1;
    applyStimulus("zero_reg", mk(0, 0, 0, 0, 0, 0, 0));
    rs_d = 5; a3_e = 5; tuse_rs_d = TUSE_NONE;
    applyStimulus("tuse_none", mk(0, 0, 0, 0, 0, 0, 0));
    tuse_rs_d = 0; we_e = 0;
    applyStimulus("we_off", mk(0, 0, 0, 0, 0, 0, 0));
    idleInputs();

    // E-stage forwarding
    rs_e = 7; rt_e = 8; a3_m = 7; we_m = 1; tnew_m = 0; a3_w = 8; we_w = 1;
    applyStimulus("fwd_e", mk(0, 0, 0, 0, 1, 2, 0));
    a3_w = 7; tnew_m = 1;
    applyStimulus("fwd_e_m_late", mk(0, 0, 0, 0, 2, 0, 0));
    idleInputs();

    // div issue with mflo in D: 1 + 10 stall cycles
    md_d = 1; md_start_e = 1; md_div_e = 1;
    applyStimulus("div_issue", mk(1, 0, 0, 0, 0, 0, 0));
    md_start_e = 0; md_div_e = 0;
    for (int i = 1; i <= 10; i++)
      applyStimulus($sformatf("div_busy_%0d", i), mk(1, 0, 0, 0, 0, 0, 1));
    applyStimulus("div_done", mk(0, 0, 0, 0, 0, 0, 0));
    idleInputs();

    // reset mid-countdown at cnt=4
    md_start_e = 1;
    applyStimulus("mult_issue", mk(0, 0, 0, 0, 0, 0, 0));
    md_start_e = 0;
    applyStimulus("mult_cnt5", mk(0, 0, 0, 0, 0, 0, 1));
    md_d = 1; rst = 1;
    applyStimulus("rst_at_cnt4", mk(1, 1, 0, 0, 0, 0, 1));
    rst = 0;
    applyStimulus("after_rst", mk(0, 0, 0, 0, 0, 0, 0));
    idleInputs();

    // mult restarted at cnt=2 reloads to 5
    md_start_e = 1;
    applyStimulus("mult2_issue", mk(0, 0, 0, 0, 0, 0, 0));
    md_start_e = 0;
    for (int i = 5; i >= 3; i--)
      applyStimulus($sformatf("mult2_cnt%0d", i), mk(0, 0, 0, 0, 0, 0, 1));
    md_start_e = 1;
    applyStimulus("restart_at_cnt2", mk(0, 0, 0, 0, 0, 0, 1));
    md_start_e = 0;
    for (int i = 5; i >= 1; i--)
      applyStimulus($sformatf("reload_cnt%0d", i), mk(0, 0, 0, 0, 0, 0, 1));
    applyStimulus("reload_done", mk(0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
